// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: edge-detects scanner key pulses, sequences code
// entry/compare, unlock hold, failed-attempt lockout and code reprogramming.
module code_lock_ctrl #(
   parameter int unsigned CODE_LEN    = 4,
   parameter logic [15:0] CODE_RST    = 16'h1234,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned OPEN_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [8:0]  dig_key,
   input  logic        fn_key,
   input  logic        clr_key,
   input  logic        ok_key,
   input  logic        start_key,
   output logic        unlocked,
   output logic        alarm,
   output logic        err,
   output logic        match,
   output logic [2:0]  state,
   output logic [2:0]  digit_cnt,
   output logic [15:0] disp,
   output logic [2:0]  fail_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_CHECK = 3'd2,
      S_OPEN  = 3'd3,
      S_PROG  = 3'd4,
      S_LOCK  = 3'd5
   } state_t;

   localparam int unsigned   MAXC    = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
   localparam int unsigned   TW      = $clog2(MAXC);
   localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYCLES - 1);
   localparam logic [2:0]    LEN3    = 3'(CODE_LEN);
   localparam logic [2:0]    MAXF3   = 3'(MAX_FAIL);

   state_t        state_q, state_d;
   logic [15:0]   code_q, code_d;
   logic [15:0]   disp_q, disp_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    fail_q, fail_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          unl_q, unl_d;
   logic          alarm_q, alarm_d;
   logic          err_q, err_d;
   logic          match_q, match_d;

   logic [8:0]    dig_prev_q;
   logic          fn_prev_q, clr_prev_q, ok_prev_q, start_prev_q;

   logic [8:0]    dig_rise;
   logic          fn_rise, clr_rise, ok_rise, start_rise;
   logic          ev_clr, ev_ok, ev_start, ev_fn, ev_dig;
   logic [3:0]    dig_val;
   logic          tmr_exp;
   logic [2:0]    fail_inc;

   assign dig_rise   = dig_key & ~dig_prev_q;
   assign fn_rise    = fn_key & ~fn_prev_q;
   assign clr_rise   = clr_key & ~clr_prev_q;
   assign ok_rise    = ok_key & ~ok_prev_q;
   assign start_rise = start_key & ~start_prev_q;

   // One winning event per cycle: clr > ok > start > fn > digit.
   assign ev_clr   = clr_rise;
   assign ev_ok    = ok_rise & ~clr_rise;
   assign ev_start = start_rise & ~clr_rise & ~ok_rise;
   assign ev_fn    = fn_rise & ~clr_rise & ~ok_rise & ~start_rise;
   assign ev_dig   = $onehot(dig_rise) & ~clr_rise & ~ok_rise & ~start_rise & ~fn_rise;

   always_comb begin
      dig_val = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (dig_rise[i]) dig_val = 4'(i + 1);
      end
   end

   assign tmr_exp  = (tmr_q == '0);
   assign fail_inc = (fail_q < MAXF3) ? fail_q + 3'd1 : fail_q;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      disp_d  = disp_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      err_d   = 1'b0;
      match_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ev_start) begin
               state_d = S_ENTRY;
               disp_d  = '0;
               cnt_d   = '0;
            end
         end

         S_ENTRY: begin
            if (ev_clr) begin
               state_d = S_IDLE;
               disp_d  = '0;
               cnt_d   = '0;
            end else if (ev_ok) begin
               state_d = S_CHECK;
            end else if (ev_start) begin
               disp_d = '0;
               cnt_d  = '0;
            end else if (ev_dig) begin
               if (cnt_q < LEN3) begin
                  disp_d = {disp_q[11:0], dig_val};
                  cnt_d  = cnt_q + 3'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_CHECK: begin
            disp_d = '0;
            cnt_d  = '0;
            if (cnt_q == LEN3 && disp_q == code_q) begin
               match_d = 1'b1;
               fail_d  = '0;
               state_d = S_OPEN;
               tmr_d   = OPEN_LD;
            end else begin
               err_d  = 1'b1;
               fail_d = fail_inc;
               if (fail_inc == MAXF3) begin
                  state_d = S_LOCK;
                  tmr_d   = LOCK_LD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_OPEN: begin
            tmr_d = tmr_q - 1'b1;
            if (tmr_exp || ev_clr || ev_start) begin
               state_d = S_IDLE;
            end else if (ev_fn) begin
               state_d = S_PROG;
               disp_d  = '0;
               cnt_d   = '0;
            end
         end

         // The OPEN hold timer keeps running while reprogramming.
         S_PROG: begin
            tmr_d = tmr_q - 1'b1;
            if (tmr_exp) begin
               state_d = S_IDLE;
               disp_d  = '0;
               cnt_d   = '0;
            end else if (ev_clr) begin
               state_d = S_OPEN;
               disp_d  = '0;
               cnt_d   = '0;
            end else if (ev_ok) begin
               disp_d = '0;
               cnt_d  = '0;
               if (cnt_q == LEN3) begin
                  code_d  = disp_q;
                  match_d = 1'b1;
                  state_d = S_OPEN;
                  tmr_d   = OPEN_LD;
               end else begin
                  err_d = 1'b1;
               end
            end else if (ev_dig) begin
               if (cnt_q < LEN3) begin
                  disp_d = {disp_q[11:0], dig_val};
                  cnt_d  = cnt_q + 3'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_LOCK: begin
            tmr_d = tmr_q - 1'b1;
            if (tmr_exp) begin
               state_d = S_IDLE;
               fail_d  = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
            disp_d  = '0;
            cnt_d   = '0;
         end
      endcase

      unl_d   = (state_d == S_OPEN) || (state_d == S_PROG);
      alarm_d = (state_d == S_LOCK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         code_q       <= CODE_RST;
         disp_q       <= '0;
         cnt_q        <= '0;
         fail_q       <= '0;
         tmr_q        <= '0;
         unl_q        <= 1'b0;
         alarm_q      <= 1'b0;
         err_q        <= 1'b0;
         match_q      <= 1'b0;
         dig_prev_q   <= '0;
         fn_prev_q    <= 1'b0;
         clr_prev_q   <= 1'b0;
         ok_prev_q    <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         disp_q       <= disp_d;
         cnt_q        <= cnt_d;
         fail_q       <= fail_d;
         tmr_q        <= tmr_d;
         unl_q        <= unl_d;
         alarm_q      <= alarm_d;
         err_q        <= err_d;
         match_q      <= match_d;
         dig_prev_q   <= dig_key;
         fn_prev_q    <= fn_key;
         clr_prev_q   <= clr_key;
         ok_prev_q    <= ok_key;
         start_prev_q <= start_key;
      end
   end

   assign unlocked  = unl_q;
   assign alarm     = alarm_q;
   assign err       = err_q;
   assign match     = match_q;
   assign state     = state_q;
   assign digit_cnt = cnt_q;
   assign disp      = disp_q;
   assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with short timers (OPEN 16, LOCKOUT 8 cycles).
module tb_code_lock_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  dig_key;
   logic        fn_key, clr_key, ok_key, start_key;
   logic        unlocked, alarm, err, match;
   logic [2:0]  state, digit_cnt, fail_cnt;
   logic [15:0] disp;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int K_CLR   = 0;
   localparam int K_OK    = 1;
   localparam int K_START = 2;
   localparam int K_FN    = 3;

   code_lock_ctrl #(
      .CODE_LEN(4), .CODE_RST(16'h1234), .MAX_FAIL(3),
      .LOCK_CYCLES(8), .OPEN_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .dig_key(dig_key), .fn_key(fn_key),
      .clr_key(clr_key), .ok_key(ok_key), .start_key(start_key),
      .unlocked(unlocked), .alarm(alarm), .err(err), .match(match),
      .state(state), .digit_cnt(digit_cnt), .disp(disp), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic keys_low();
      dig_key = '0; fn_key = 1'b0; clr_key = 1'b0; ok_key = 1'b0; start_key = 1'b0;
   endtask

   // Idle cycle, then the key is high for exactly one edge; outputs then show its effect.
   task automatic press(input int k);
      tick();
      case (k)
         K_CLR:   clr_key = 1'b1;
         K_OK:    ok_key = 1'b1;
         K_START: start_key = 1'b1;
         default: fn_key = 1'b1;
      endcase
      tick();
      keys_low();
   endtask

   task automatic digit(input logic [3:0] d);
      tick();
      dig_key = '0;
      dig_key[int'(d) - 1] = 1'b1;
      tick();
      keys_low();
   endtask

   task automatic enter(input logic [15:0] code);
      press(K_START);
      for (int i = 3; i >= 0; i--) digit(code[4*i +: 4]);
   endtask

   task automatic ok_done();
      press(K_OK);
      tick();
   endtask

   int ncyc;

   initial begin
      keys_low();
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_unlocked", 32'(unlocked), 32'd0);
      check("rst_disp", 32'(disp), 32'h0);
      check("rst_misc", 32'({alarm, err, match, digit_cnt, fail_cnt}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Correct default code and OPEN hold length
      enter(16'h1234);
      check("entry_disp", 32'(disp), 32'h1234);
      check("entry_cnt", 32'(digit_cnt), 32'd4);
      check("entry_state", 32'(state), 32'd1);
      press(K_OK);
      check("check_state", 32'(state), 32'd2);
      check("no_early_match", 32'(match), 32'd0);
      tick();
      check("match_pulse", 32'(match), 32'd1);
      check("open_state", 32'(state), 32'd3);
      check("open_unlocked", 32'(unlocked), 32'd1);
      ncyc = 1;
      tick();
      check("match_one_cycle", 32'(match), 32'd0);
      if (unlocked) ncyc++;
      for (int i = 0; i < 100 && unlocked; i++) begin
         tick();
         if (unlocked) ncyc++;
      end
      check("open_cycles", 32'(ncyc), 32'd16);
      check("relock_idle", 32'(state), 32'd0);

      // Three mismatches trigger lockout
      for (int a = 1; a <= 3; a++) begin
         enter(16'h1235);
         ok_done();
         check("mismatch_err", 32'(err), 32'd1);
         check("fail_cnt", 32'(fail_cnt), 32'(a));
         if (a < 3) check("mismatch_idle", 32'(state), 32'd0);
      end
      check("lock_state", 32'(state), 32'd5);
      check("lock_alarm", 32'(alarm), 32'd1);
      ncyc = 1;
      for (int i = 0; i < 100 && alarm; i++) begin
         clr_key   = (i == 1);
         start_key = (i == 3);
         tick();
         if (alarm) ncyc++;
      end
      keys_low();
      check("lock_cycles", 32'(ncyc), 32'd8);
      check("lock_exit_idle", 32'(state), 32'd0);
      check("lock_exit_fail", 32'(fail_cnt), 32'd0);

      // Entry buffer limits
      enter(16'h1234);
      digit(4'd5);
      check("overflow_err", 32'(err), 32'd1);
      check("overflow_disp", 32'(disp), 32'h1234);
      check("overflow_cnt", 32'(digit_cnt), 32'd4);
      press(K_CLR);
      check("clr_idle", 32'(state), 32'd0);
      check("clr_disp", 32'(disp), 32'h0);
      press(K_START);
      digit(4'd1);
      digit(4'd2);
      ok_done();
      check("short_err", 32'(err), 32'd1);
      check("short_fail", 32'(fail_cnt), 32'd1);
      check("short_idle", 32'(state), 32'd0);

      // Reprogramming to 9876
      enter(16'h1234);
      ok_done();
      check("unlock_fail_clr", 32'(fail_cnt), 32'd0);
      press(K_FN);
      check("prog_state", 32'(state), 32'd4);
      check("prog_unlocked", 32'(unlocked), 32'd1);
      check("prog_disp", 32'(disp), 32'h0);
      digit(4'd9); digit(4'd8); digit(4'd7); digit(4'd6);
      check("prog_disp_full", 32'(disp), 32'h9876);
      press(K_OK);
      check("prog_match", 32'(match), 32'd1);
      check("prog_open", 32'(state), 32'd3);
      for (int i = 0; i < 100 && state != 3'd0; i++) tick();
      check("prog_relock", 32'(state), 32'd0);
      check("prog_relock_unl", 32'(unlocked), 32'd0);
      enter(16'h9876);
      ok_done();
      check("new_code_unl", 32'(unlocked), 32'd1);
      press(K_CLR);
      check("open_clr_idle", 32'(state), 32'd0);
      check("open_clr_unl", 32'(unlocked), 32'd0);
      enter(16'h1234);
      ok_done();
      check("old_code_err", 32'(err), 32'd1);
      check("old_code_locked", 32'(unlocked), 32'd0);

      // Simultaneous and held keys
      press(K_START);
      digit(4'd1);
      tick();
      clr_key = 1'b1;
      ok_key  = 1'b1;
      tick();
      keys_low();
      check("clr_beats_ok", 32'(state), 32'd0);
      check("clr_ok_disp", 32'(disp), 32'h0);
      tick();
      check("clr_ok_no_check", 32'(state), 32'd0);
      press(K_START);
      tick();
      dig_key = 9'b000000101;
      tick();
      keys_low();
      check("multi_digit_cnt", 32'(digit_cnt), 32'd0);
      check("multi_digit_err", 32'(err), 32'd0);
      tick();
      dig_key[4] = 1'b1;
      repeat (40) tick();
      keys_low();
      check("held_digit_cnt", 32'(digit_cnt), 32'd1);
      check("held_digit_disp", 32'(disp), 32'h5);

      // Asynchronous reset while open restores the default code
      press(K_CLR);
      enter(16'h9876);
      ok_done();
      check("pre_rst_unl", 32'(unlocked), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_unl", 32'(unlocked), 32'd0);
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_disp", 32'(disp), 32'h0);
      check("async_rst_misc", 32'({alarm, err, match, digit_cnt, fail_cnt}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      enter(16'h9876);
      ok_done();
      check("rst_9876_err", 32'(err), 32'd1);
      check("rst_9876_locked", 32'(unlocked), 32'd0);
      enter(16'h1234);
      ok_done();
      check("rst_1234_match", 32'(match), 32'd1);
      check("rst_1234_unl", 32'(unlocked), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
